// File: rtl/axis_addr_reader.sv
// Address-stream to AXI4-Lite read bridge: one AR per input address, read data streamed out in order.
// Build option: define ERR_COUNT_EN to count non-OKAY read responses on err_count.
module axis_addr_reader #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [2:0]  M_AXI_ARPROT,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [15:0] err_count
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]           outstanding;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_W-1:0]           tag_wr_ptr;
    logic [PTR_W-1:0]           tag_rd_ptr;
    logic                       s_fire;
    logic                       r_fire;
    logic                       m_fire;

    // Outstanding counts until the beat leaves M_AXIS, so it also bounds the tag FIFO occupancy.
    assign S_AXIS_TREADY = !rst && (outstanding < MAX_CNT) && (!M_AXI_ARVALID || M_AXI_ARREADY);
    assign M_AXI_RREADY  = !rst && (!M_AXIS_TVALID || M_AXIS_TREADY);
    assign M_AXI_ARPROT  = 3'b000;

    assign s_fire = S_AXIS_TVALID && S_AXIS_TREADY;
    assign r_fire = M_AXI_RVALID && M_AXI_RREADY;
    assign m_fire = M_AXIS_TVALID && M_AXIS_TREADY;

    // NOTE: state is updated with non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= '0;
        end else if (s_fire) begin
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= S_AXIS_TDATA;
        end else if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({s_fire, m_fire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // NOTE: the tag store is only MAX_OUTSTANDING flops, so it is cleared along with its pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_mem    <= '0;
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (s_fire) begin
                tag_mem[tag_wr_ptr] <= S_AXIS_TLAST;
                tag_wr_ptr          <= tag_wr_ptr + PTR_W'(1);
            end
            if (r_fire) begin
                tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (r_fire) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= M_AXI_RDATA;
            M_AXIS_TLAST  <= tag_mem[tag_rd_ptr];
        end else if (m_fire) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

`ifdef ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (r_fire && (M_AXI_RRESP != 2'b00) && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    // Response code is deliberately ignored in this build; data is forwarded either way.
    logic unused_rresp;
    assign unused_rresp = ^M_AXI_RRESP;
    assign err_count    = 16'h0000;
`endif

endmodule
